fb_arbiter: RTL and testbench
=============================

Name: fb_arbiter

Overview:
Arbitrates one single-port synchronous frame-buffer RAM between three users: VGA scan-out (display reader), two game-logic pixel writers, and an internal bulk-clear engine. Sits between vga_sync/pixel-address generation and the frame-buffer BRAM. Runs entirely on the 25 MHz pixel clock domain.

Parameters:
ADDR_W, 17, frame-buffer address width (320x240 = 76800 words)
DATA_W, 3, pixel width (RGB, one bit each)
DEPTH, 76800, number of valid words; clear runs from 0 to DEPTH-1
CLEAR_COLOR, 3'b000, value written by the clear engine

Ports:
clk  in  1  25 MHz pixel clock
reset  in  1  asynchronous, active-low reset
disp_req  in  1  display read request this cycle (driven high during active video)
disp_addr  in  ADDR_W  display read address
disp_data  out  DATA_W  read data, valid with disp_valid
disp_valid  out  1  pulses 1 cycle after a granted disp_req
wr0_req  in  1  writer 0 request; held with addr/data until granted
wr0_addr  in  ADDR_W  writer 0 address
wr0_data  in  DATA_W  writer 0 data
wr0_gnt  out  1  one-cycle grant; write committed this cycle
wr1_req, wr1_addr, wr1_data, wr1_gnt  as writer 0
clear_start  in  1  single-cycle pulse: clear whole buffer
clear_busy  out  1  high while clear in progress
clear_done  out  1  one-cycle pulse after last clear write
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, 1-cycle latency

Behaviour:
- Reset (reset low, async): all outputs 0, clear counter 0, round-robin pointer = writer 0, FSM IDLE.
- Per-cycle priority, combinational select registered into nothing: display > clear > writers. Exactly one owner per cycle; mem_en high only when an owner exists.
- Display: disp_req always wins; mem_we=0, mem_addr=disp_addr. disp_valid registered 1 cycle later; disp_data = mem_rdata in that cycle, else 0.
- Writers: only when disp_req=0 and not clearing. If one requests it wins; if both, round-robin: pointer names preferred writer, flips to the other after each writer grant. Grant cycle: mem_we=1, addr/data from winner, winner's gnt=1. Writer must hold req/addr/data until gnt; dropping req before gnt is legal (request withdrawn, no write).
- Clear FSM states: IDLE, CLEAR, DONE.
  IDLE -> CLEAR on clear_start (counter=0, clear_busy=1 next cycle).
  CLEAR: each cycle with disp_req=0 writes CLEAR_COLOR at counter, counter++; disp_req=1 stalls counter. Writing address DEPTH-1 -> DONE.
  DONE: clear_done=1 for one cycle, clear_busy=0, -> IDLE.
  clear_start while CLEAR or DONE: ignored.
- Writers are fully blocked during CLEAR (gnt stays 0, requests held).
- Counter never exceeds DEPTH-1; no wrap.
- Reset mid-clear: aborts, no clear_done, FSM IDLE.
- No combinational path from mem_rdata to any mem_* output.

Decomposition:
- Shared package fb_pkg: ADDR_W, DATA_W, DEPTH, CLEAR_COLOR, FSM state typedef (IDLE/CLEAR/DONE).
- One natural sub-module: rr_arb2 (2-input round-robin arbiter with pointer register, enable input).

Test Plan:
- Reset, then disp_req=1 addr 5 with RAM word 5 = 3'b101 -> next cycle disp_valid=1, disp_data=3'b101; wr0_req held high gets no gnt.
- disp_req=0, wr0_req addr 10 data 3'b011 -> wr0_gnt same cycle, mem_we=1, mem_addr=10, mem_wdata=3'b011; readback later returns 3'b011.
- Both writers requesting continuously, disp_req=0 -> grants alternate wr0,wr1,wr0,wr1 starting with wr0 after reset.
- clear_start with disp_req toggling 50% -> exactly 76800 clear writes, addresses 0..76799 in order, clear_done single pulse, clear_busy low after; no writer grants during clear.
- clear_start pulsed again mid-clear -> ignored, counter not reset; reset low mid-clear -> all outputs 0 immediately, no clear_done.
- wr1_req asserted then dropped while display busy -> no write to wr1_addr, no wr1_gnt.

Source files
------------

// File: rtl/fb_arbiter_pkg.sv
// Shared constants and clear-engine state type for the frame-buffer arbiter.
package fb_pkg;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 3;
  localparam int DEPTH  = 76800;
  localparam logic [DATA_W-1:0] CLEAR_COLOR = 3'b000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

endpackage

// File: rtl/fb_arbiter_if.sv
// Bundle of user-side and RAM-side signals around the frame-buffer arbiter.
// Handshake: a writer raises wrN_req with addr/data and holds them until the
// cycle wrN_gnt is high; that cycle commits the write. disp_req is never stalled.
interface fb_arbiter_if;
  import fb_pkg::*;

  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;

  logic              wr0_req;
  logic [ADDR_W-1:0] wr0_addr;
  logic [DATA_W-1:0] wr0_data;
  logic              wr0_gnt;

  logic              wr1_req;
  logic [ADDR_W-1:0] wr1_addr;
  logic [DATA_W-1:0] wr1_data;
  logic              wr1_gnt;

  logic              clear_start;
  logic              clear_busy;
  logic              clear_done;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  disp_req, disp_addr,
    input  wr0_req, wr0_addr, wr0_data,
    input  wr1_req, wr1_addr, wr1_data,
    input  clear_start, mem_rdata,
    output disp_data, disp_valid, wr0_gnt, wr1_gnt,
    output clear_busy, clear_done,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output disp_req, disp_addr,
    output wr0_req, wr0_addr, wr0_data,
    output wr1_req, wr1_addr, wr1_data,
    output clear_start, mem_rdata,
    input  disp_data, disp_valid, wr0_gnt, wr1_gnt,
    input  clear_busy, clear_done,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/fb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer moves to the loser after a grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (en) begin
            if (req == 2'b11) begin
                gnt = ptr_q ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
            if (gnt[0]) begin
                ptr_d = 1'b1;
            end else if (gnt[1]) begin
                ptr_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fb_arbiter.sv
// Single-port frame-buffer arbiter: display read > bulk clear > two pixel writers.
module fb_arbiter
    import fb_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    fb_arbiter_if.slave        bus,
    output clr_state_e         dbg_state
);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              disp_valid_q, disp_valid_d;

    logic              disp_own;
    logic              clear_own;
    logic              wr_en;
    logic [1:0]        wr_gnt;

    // Reset gates the combinational outputs so they read 0 while reset is low.
    assign disp_own  = bus.disp_req & reset;
    assign clear_own = (state_q == CLEAR) & ~bus.disp_req;
    assign wr_en     = reset & ~bus.disp_req & (state_q != CLEAR);

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst_n (reset),
        .en    (wr_en),
        .req   ({bus.wr1_req, bus.wr0_req}),
        .gnt   (wr_gnt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.clear_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (!bus.disp_req) begin
                    if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (disp_own) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.disp_addr;
        end else if (clear_own) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = cnt_q;
            bus.mem_wdata = CLEAR_COLOR;
        end else if (wr_gnt[0]) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = bus.wr0_addr;
            bus.mem_wdata = bus.wr0_data;
        end else if (wr_gnt[1]) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = bus.wr1_addr;
            bus.mem_wdata = bus.wr1_data;
        end
    end

    assign disp_valid_d   = disp_own;
    assign bus.disp_valid = disp_valid_q;
    assign bus.disp_data  = disp_valid_q ? bus.mem_rdata : '0;
    assign bus.wr0_gnt    = wr_gnt[0];
    assign bus.wr1_gnt    = wr_gnt[1];
    assign bus.clear_busy = (state_q == CLEAR);
    assign bus.clear_done = (state_q == DONE);
    assign dbg_state      = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            disp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            disp_valid_q <= disp_valid_d;
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: vector table, randomized traffic against a queue-based
// reference model, and hand-written clear / reset / withdrawal sequences.
module tb_fb_arbiter;
  import fb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  clr_state_e dbg_state;

  initial clk = 1'b0;
  always #20 clk = ~clk;

  fb_arbiter_if bus ();

  fb_arbiter u_dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- RAM model ----------------
  logic [DATA_W-1:0] ram     [0:DEPTH-1];
  logic [DATA_W-1:0] ref_mem [0:DEPTH-1];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the RAM each cycle, derived from the priority rules.
  logic [DATA_W-1:0] exp_q [$];
  bit m_clearing, m_done, m_pref, mon_en;
  int m_clr_addr;

  task automatic model_reset();
    m_clearing = 0;
    m_done     = 0;
    m_pref     = 0;
    m_clr_addr = 0;
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (reset && mon_en) begin : model
      logic [DATA_W-1:0] d;
      bit win, cur_done, e_en, e_we, e_g0, e_g1;
      int e_addr, e_wd;
      if (exp_q.size() > 0) begin
        d = exp_q.pop_front();
        chk("m_disp_valid", bus.disp_valid, 1);
        chk("m_disp_data", bus.disp_data, d);
      end else begin
        chk("m_disp_valid", bus.disp_valid, 0);
        chk("m_disp_data", bus.disp_data, 0);
      end
      e_en = 0; e_we = 0; e_g0 = 0; e_g1 = 0; e_addr = 0; e_wd = 0; win = 0;
      if (bus.disp_req) begin
        e_en = 1; e_addr = int'(bus.disp_addr);
        exp_q.push_back(ref_mem[bus.disp_addr]);
      end else if (m_clearing) begin
        e_en = 1; e_we = 1; e_addr = m_clr_addr; e_wd = int'(CLEAR_COLOR);
      end else if (bus.wr0_req || bus.wr1_req) begin
        win  = (bus.wr0_req && bus.wr1_req) ? m_pref : bus.wr1_req;
        e_en = 1; e_we = 1; e_g0 = !win; e_g1 = win;
        e_addr = win ? int'(bus.wr1_addr) : int'(bus.wr0_addr);
        e_wd   = win ? int'(bus.wr1_data) : int'(bus.wr0_data);
      end
      chk("m_mem_en", bus.mem_en, e_en);
      chk("m_mem_we", bus.mem_we, e_we);
      chk("m_mem_addr", bus.mem_addr, e_addr);
      chk("m_mem_wdata", bus.mem_wdata, e_wd);
      chk("m_wr0_gnt", bus.wr0_gnt, e_g0);
      chk("m_wr1_gnt", bus.wr1_gnt, e_g1);
      chk("m_clear_busy", bus.clear_busy, m_clearing);
      chk("m_clear_done", bus.clear_done, m_done);
      // advance model to the next cycle
      if (e_we) ref_mem[e_addr] = DATA_W'(e_wd);
      if (e_g0 || e_g1) m_pref = !win;
      cur_done = m_done;
      m_done   = 0;
      if (m_clearing) begin
        if (!bus.disp_req) begin
          if (m_clr_addr == DEPTH - 1) begin
            m_clearing = 0;
            m_done     = 1;
          end else begin
            m_clr_addr++;
          end
        end
      end else if (!cur_done && bus.clear_start) begin
        m_clearing = 1;
        m_clr_addr = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.disp_req = 0; bus.disp_addr = '0;
    bus.wr0_req = 0; bus.wr0_addr = '0; bus.wr0_data = '0;
    bus.wr1_req = 0; bus.wr1_addr = '0; bus.wr1_data = '0;
    bus.clear_start = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_en"}, bus.mem_en, 0);
    chk({tag, "_mem_we"}, bus.mem_we, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_wr0_gnt"}, bus.wr0_gnt, 0);
    chk({tag, "_wr1_gnt"}, bus.wr1_gnt, 0);
    chk({tag, "_clear_busy"}, bus.clear_busy, 0);
    chk({tag, "_clear_done"}, bus.clear_done, 0);
    chk({tag, "_disp_valid"}, bus.disp_valid, 0);
    chk({tag, "_disp_data"}, bus.disp_data, 0);
    chk({tag, "_state"}, dbg_state, IDLE);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic d_req; int d_addr;
    logic w0_req; int w0_addr; int w0_data;
    logic w1_req; int w1_addr; int w1_data;
    logic e_en; logic e_we; int e_addr; int e_wd;
    logic e_g0; logic e_g1; logic e_dv; int e_dd;
  } vec_t;

  vec_t vecs [11];
  bit g0_last, g1_last;

  initial begin
    mon_en = 0;
    model_reset();
    reset = 0;
    idle_inputs();
    bus.mem_rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = DATA_W'($urandom_range(0, 7));
      ref_mem[i] = ram[i];
    end
    ram[5] = 3'b101; ref_mem[5] = 3'b101;

    vecs[0]  = '{1, 5,  1, 10, 3, 0, 20, 6,  1, 0, 5,  0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0,  1, 10, 3, 0, 20, 6,  1, 1, 10, 3, 1, 0, 1, 5};
    vecs[2]  = '{0, 0,  1, 10, 3, 1, 20, 6,  1, 1, 20, 6, 0, 1, 0, 0};
    vecs[3]  = '{0, 0,  1, 10, 3, 1, 20, 6,  1, 1, 10, 3, 1, 0, 0, 0};
    vecs[4]  = '{0, 0,  1, 10, 3, 1, 20, 6,  1, 1, 20, 6, 0, 1, 0, 0};
    vecs[5]  = '{1, 10, 1, 10, 3, 1, 20, 6,  1, 0, 10, 0, 0, 0, 0, 0};
    vecs[6]  = '{1, 20, 0, 0,  0, 0, 0,  0,  1, 0, 20, 0, 0, 0, 1, 3};
    vecs[7]  = '{0, 0,  0, 0,  0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 1, 6};
    vecs[8]  = '{0, 0,  0, 0,  0, 1, 7,  5,  1, 1, 7,  5, 0, 1, 0, 0};
    vecs[9]  = '{0, 0,  1, 11, 1, 1, 7,  5,  1, 1, 11, 1, 1, 0, 0, 0};
    vecs[10] = '{0, 0,  1, 11, 1, 1, 7,  5,  1, 1, 7,  5, 0, 1, 0, 0};

    // reset state
    #5;
    check_all_zero("reset");
    step();
    reset = 1;
    mon_en = 1;

    // table-driven vectors
    for (int i = 0; i < 11; i++) begin
      step();
      bus.disp_req = vecs[i].d_req;  bus.disp_addr = ADDR_W'(vecs[i].d_addr);
      bus.wr0_req  = vecs[i].w0_req; bus.wr0_addr  = ADDR_W'(vecs[i].w0_addr);
      bus.wr0_data = DATA_W'(vecs[i].w0_data);
      bus.wr1_req  = vecs[i].w1_req; bus.wr1_addr  = ADDR_W'(vecs[i].w1_addr);
      bus.wr1_data = DATA_W'(vecs[i].w1_data);
      @(negedge clk);
      chk("v_mem_en", bus.mem_en, vecs[i].e_en);
      chk("v_mem_we", bus.mem_we, vecs[i].e_we);
      chk("v_mem_addr", bus.mem_addr, vecs[i].e_addr);
      chk("v_mem_wdata", bus.mem_wdata, vecs[i].e_wd);
      chk("v_wr0_gnt", bus.wr0_gnt, vecs[i].e_g0);
      chk("v_wr1_gnt", bus.wr1_gnt, vecs[i].e_g1);
      chk("v_disp_valid", bus.disp_valid, vecs[i].e_dv);
      chk("v_disp_data", bus.disp_data, vecs[i].e_dd);
    end

    // randomized traffic with held/withdrawn writer requests
    step(); idle_inputs();
    @(negedge clk);
    g0_last = 0; g1_last = 0;
    for (int c = 0; c < 1500; c++) begin
      step();
      bus.disp_req  = ($urandom_range(0, 9) < 3);
      bus.disp_addr = ADDR_W'($urandom_range(0, 63));
      if (bus.wr0_req && !g0_last) begin
        if ($urandom_range(0, 15) == 0) bus.wr0_req = 0;
      end else begin
        bus.wr0_req  = ($urandom_range(0, 2) != 0);
        bus.wr0_addr = ADDR_W'($urandom_range(0, 63));
        bus.wr0_data = DATA_W'($urandom_range(0, 7));
      end
      if (bus.wr1_req && !g1_last) begin
        if ($urandom_range(0, 15) == 0) bus.wr1_req = 0;
      end else begin
        bus.wr1_req  = ($urandom_range(0, 2) != 0);
        bus.wr1_addr = ADDR_W'($urandom_range(0, 63));
        bus.wr1_data = DATA_W'($urandom_range(0, 7));
      end
      @(negedge clk);
      g0_last = bus.wr0_gnt;
      g1_last = bus.wr1_gnt;
    end

    // withdrawn writer request while display owns the RAM
    step(); idle_inputs();
    bus.wr0_req = 1; bus.wr0_addr = ADDR_W'(40); bus.wr0_data = 3'b010;
    @(negedge clk);
    chk("wd_seed_gnt", bus.wr0_gnt, 1);
    step(); idle_inputs();
    bus.disp_req = 1; bus.disp_addr = ADDR_W'(0);
    bus.wr1_req = 1; bus.wr1_addr = ADDR_W'(40); bus.wr1_data = 3'b111;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("wd_wr1_gnt", bus.wr1_gnt, 0);
      step();
      if (c == 2) begin bus.wr1_req = 0; bus.disp_req = 0; end
    end
    bus.disp_req = 1; bus.disp_addr = ADDR_W'(40);
    step(); bus.disp_req = 0;
    @(negedge clk);
    chk("wd_readback_valid", bus.disp_valid, 1);
    chk("wd_readback_data", bus.disp_data, 3'b010);

    // full clear with display interleaving and a repeated start pulse
    begin : clear_seq
      int cyc, seen, busy_gnt, done_cnt;
      bit done_seen;
      cyc = 0; seen = 0; busy_gnt = 0; done_cnt = 0; done_seen = 0;
      step(); idle_inputs(); bus.clear_start = 1;
      @(negedge clk);
      while (!done_seen && cyc < 100000) begin
        step();
        bus.clear_start = (cyc == 500);
        bus.disp_req    = (cyc < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.disp_addr   = ADDR_W'($urandom_range(0, DEPTH - 1));
        bus.wr0_req = 1; bus.wr0_addr = ADDR_W'(33); bus.wr0_data = 3'b110;
        @(negedge clk);
        if (bus.clear_busy && bus.mem_we) begin
          chk("clear_addr_order", bus.mem_addr, seen);
          seen++;
        end
        if (bus.clear_busy && (bus.wr0_gnt || bus.wr1_gnt)) busy_gnt++;
        if (bus.clear_done) begin
          done_seen = 1;
          done_cnt++;
          chk("wr0_gnt_at_done", bus.wr0_gnt, 1);
        end
        cyc++;
      end
      if (!done_seen) chk("clear_timeout", 0, 1);
      chk("clear_writes", seen, DEPTH);
      chk("clear_busy_gnts", busy_gnt, 0);
      step(); idle_inputs();
      @(negedge clk);
      chk("clear_done_pulse", bus.clear_done, 0);
      chk("clear_busy_after", bus.clear_busy, 0);
      chk("clear_done_count", done_cnt, 1);
    end

    // readback after clear
    step(); bus.disp_req = 1; bus.disp_addr = ADDR_W'(DEPTH - 1);
    step(); bus.disp_addr = ADDR_W'(33);
    @(negedge clk);
    chk("rb_last_word", bus.disp_data, 0);
    step(); bus.disp_req = 0;
    @(negedge clk);
    chk("rb_wr0_after_clear", bus.disp_data, 3'b110);

    // reset in the middle of a clear
    step(); idle_inputs(); bus.clear_start = 1;
    for (int c = 0; c < 300; c++) begin
      step(); bus.clear_start = 0;
    end
    @(negedge clk);
    chk("abort_busy_before", bus.clear_busy, 1);
    step();
    mon_en = 0;
    reset = 0;
    bus.disp_req = 1; bus.disp_addr = ADDR_W'(9);
    bus.wr0_req = 1; bus.wr0_addr = ADDR_W'(50); bus.wr0_data = 3'b001;
    bus.wr1_req = 1; bus.wr1_addr = ADDR_W'(51); bus.wr1_data = 3'b010;
    #1;
    check_all_zero("abort");
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort_no_done", bus.clear_done, 0);
    end
    step();
    reset = 1;
    bus.disp_req = 0;
    mon_en = 1;
    // both writers held: grants alternate starting with writer 0
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("alt_wr0_gnt", bus.wr0_gnt, (c % 2) == 0);
      chk("alt_wr1_gnt", bus.wr1_gnt, (c % 2) == 1);
      chk("alt_clear_busy", bus.clear_busy, 0);
      step();
    end
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    mon_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
